// File: rtl/rx_arb_pkg.sv
// rx_arb_pkg: FSM encoding, OUT_DATA field layout and shared helpers for rx_link_arbiter.
package rx_arb_pkg;

    localparam int DATA_SIZE   = 25;
    localparam int ID_LSB      = 25;
    localparam int ID_WIDTH    = 3;
    localparam int OUT_WIDTH   = 32;
    localparam int BURST_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    typedef logic [ID_WIDTH-1:0] chan_id_t;

    function automatic logic [OUT_WIDTH-1:0] pack_out(input chan_id_t id,
                                                      input logic [DATA_SIZE-1:0] word);
        logic [OUT_WIDTH-1:0] packed_word;
        packed_word = '0;
        packed_word[ID_LSB +: ID_WIDTH] = id;
        packed_word[DATA_SIZE-1:0]      = word;
        return packed_word;
    endfunction

endpackage

// File: rtl/rx_rr_select.sv
// rx_rr_select: combinational rotating-priority pick of the first requester after 'last'.
module rx_rr_select #(
    parameter int NUM_RX = 8
) (
    input  logic [NUM_RX-1:0]               req,
    input  logic [rx_arb_pkg::ID_WIDTH-1:0] last,
    output logic                            hit,
    output logic [rx_arb_pkg::ID_WIDTH-1:0] idx
);
    import rx_arb_pkg::*;

    chan_id_t cand;

    // Walk the ring from the furthest slot back to the nearest so the nearest requester after 'last' wins.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = NUM_RX; k >= 1; k--) begin
            cand = chan_id_t'((int'(last) + k) % NUM_RX);
            if (req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rx_link_arbiter.sv
// rx_link_arbiter: round-robin burst arbiter draining NUM_RX FWFT receiver FIFOs onto one valid/ready stream.
// Define RX_ARB_WORD_CNT_EN to build the saturating accepted-word counter behind WORD_CNT.
module rx_link_arbiter #(
    parameter int NUM_RX    = 8,
    parameter int MAX_BURST = 16,
    parameter int DATA_SIZE = 25
) (
    input  logic                             BUS_CLK,
    input  logic                             RESET,
    input  logic [NUM_RX-1:0]                RX_EMPTY,
    input  logic [NUM_RX*DATA_SIZE-1:0]      RX_DATA,
    output logic [NUM_RX-1:0]                RX_READ,
    input  logic [NUM_RX-1:0]                EN_MASK,
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic [rx_arb_pkg::OUT_WIDTH-1:0] OUT_DATA,
    output logic                             BUSY,
    output logic [31:0]                      WORD_CNT
);
    import rx_arb_pkg::*;

    localparam logic [BURST_WIDTH-1:0] BURST_LAST = BURST_WIDTH'(MAX_BURST - 1);
    localparam chan_id_t               LAST_INIT  = chan_id_t'(NUM_RX - 1);

    arb_state_t             state;
    arb_state_t             state_next;
    chan_id_t               grant;
    chan_id_t               grant_next;
    chan_id_t               last;
    chan_id_t               last_next;
    logic [BURST_WIDTH-1:0] burst_cnt;
    logic [BURST_WIDTH-1:0] burst_next;

    logic [NUM_RX-1:0]    eligible;
    logic                 sel_hit;
    chan_id_t             sel_idx;
    logic                 cur_empty;
    logic                 cur_en;
    logic [DATA_SIZE-1:0] cur_word;
    logic                 handshake;
    logic                 burst_done;

    assign eligible = EN_MASK & ~RX_EMPTY;

    rx_rr_select #(
        .NUM_RX (NUM_RX)
    ) u_select (
        .req  (eligible),
        .last (last),
        .hit  (sel_hit),
        .idx  (sel_idx)
    );

    // RESET masks the handshake so no word is popped in a cycle whose state is being discarded.
    always_comb begin
        cur_empty  = RX_EMPTY[grant];
        cur_en     = EN_MASK[grant];
        cur_word   = RX_DATA[int'(grant)*DATA_SIZE +: DATA_SIZE];
        OUT_VALID  = (state == XFER) && !cur_empty && !RESET;
        OUT_DATA   = (state == XFER) ? pack_out(grant, cur_word) : '0;
        handshake  = OUT_VALID && OUT_READY;
        burst_done = handshake && (burst_cnt == BURST_LAST);
        RX_READ    = '0;
        if (handshake) begin
            RX_READ[grant] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last;
        burst_next = burst_cnt;
        case (state)
            IDLE: begin
                if (sel_hit) begin
                    state_next = XFER;
                    grant_next = sel_idx;
                    burst_next = '0;
                end
            end
            XFER: begin
                if (handshake) begin
                    burst_next = burst_cnt + 1'b1;
                end
                // A handshake in the same cycle as a mask drop still completes before leaving.
                if (burst_done || cur_empty || !cur_en) begin
                    state_next = IDLE;
                    last_next  = grant;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (RESET) begin
            state     <= IDLE;
            grant     <= '0;
            last      <= LAST_INIT;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            last      <= last_next;
            burst_cnt <= burst_next;
        end
    end

    assign BUSY = (state == XFER);

`ifdef RX_ARB_WORD_CNT_EN
    logic [31:0] word_cnt;

    always_ff @(posedge BUS_CLK) begin
        if (RESET) begin
            word_cnt <= '0;
        end else if (handshake && (word_cnt != 32'hFFFF_FFFF)) begin
            word_cnt <= word_cnt + 32'd1;
        end
    end

    assign WORD_CNT = word_cnt;
`else
    assign WORD_CNT = '0;
`endif

endmodule

// File: tb/tb_rx_link_arbiter.sv
// tb_rx_link_arbiter: self-checking bench with FWFT FIFO models, directed tables and a randomized reference model.
// Expected WORD_CNT follows RX_ARB_WORD_CNT_EN as seen by this compilation.
module tb_rx_link_arbiter;

    localparam int NUM_RX    = 8;
    localparam int MAX_BURST = 4;
    localparam int DSZ       = 25;
`ifdef RX_ARB_WORD_CNT_EN
    localparam bit WC_EN = 1'b1;
`else
    localparam bit WC_EN = 1'b0;
`endif

    typedef logic [DSZ-1:0] word_q_t [$];

    typedef struct {
        logic              rst;
        logic              rdy;
        logic [NUM_RX-1:0] en;
        logic              exp_valid;
        logic              exp_busy;
        logic [NUM_RX-1:0] exp_read;
        logic [31:0]       exp_data;
    } vec_t;

    logic                  BUS_CLK = 1'b0;
    logic                  RESET;
    logic [NUM_RX-1:0]     RX_EMPTY;
    logic [NUM_RX*DSZ-1:0] RX_DATA;
    logic [NUM_RX-1:0]     RX_READ;
    logic [NUM_RX-1:0]     EN_MASK;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [31:0]           OUT_DATA;
    logic                  BUSY;
    logic [31:0]           WORD_CNT;

    word_q_t fifo [NUM_RX];
    int      pop_log [$];
    int      tests_run    = 0;
    int      tests_failed = 0;

    // Reference model: who owns the stream, how many words taken this grant, words accepted since reset.
    bit     model_on = 1'b0;
    bit     m_busy   = 1'b0;
    int     m_grant  = 0;
    int     m_last   = NUM_RX - 1;
    int     m_taken  = 0;
    longint m_words  = 0;

    logic              s_valid;
    logic              s_busy;
    logic [NUM_RX-1:0] s_read;
    logic [31:0]       s_data;
    logic [31:0]       s_wc;

    vec_t              tbl [8];
    int                ord [$];
    int                seq_ch  [6];
    int                seq_len [6];
    int                cyc;
    int                expw;
    int                ch;
    logic [31:0]       hold_exp;
    logic [NUM_RX-1:0] en_r;

    always #5 BUS_CLK = ~BUS_CLK;

    rx_link_arbiter #(
        .NUM_RX    (NUM_RX),
        .MAX_BURST (MAX_BURST),
        .DATA_SIZE (DSZ)
    ) dut (
        .BUS_CLK   (BUS_CLK),
        .RESET     (RESET),
        .RX_EMPTY  (RX_EMPTY),
        .RX_DATA   (RX_DATA),
        .RX_READ   (RX_READ),
        .EN_MASK   (EN_MASK),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .BUSY      (BUSY),
        .WORD_CNT  (WORD_CNT)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveFifoPorts();
        for (int i = 0; i < NUM_RX; i++) begin
            RX_EMPTY[i] = (fifo[i].size() == 0);
            RX_DATA[i*DSZ +: DSZ] = (fifo[i].size() == 0) ? {DSZ{1'b0}} : fifo[i][0];
        end
    endtask

    task automatic pushWords(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            fifo[c].push_back(DSZ'($urandom));
        end
    endtask

    function automatic int countPops(input int c);
        int n;
        n = 0;
        foreach (pop_log[i]) begin
            if (pop_log[i] == c) n++;
        end
        return n;
    endfunction

    // One clock cycle: drive inputs, sample and compare at the falling edge, then pop FIFOs and advance the model.
    task automatic applyStimulus(input logic rst, input logic rdy, input logic [NUM_RX-1:0] en);
        logic              e_valid;
        logic [NUM_RX-1:0] e_read;
        logic [31:0]       e_data;
        logic [31:0]       e_wc;
        logic [DSZ-1:0]    head;
        bit                avail;
        bit                hs;
        int                c;
        RESET     = rst;
        OUT_READY = rdy;
        EN_MASK   = en;
        driveFifoPorts();
        @(negedge BUS_CLK);
        e_valid = 1'b0;
        e_read  = '0;
        e_data  = '0;
        avail   = 1'b0;
        hs      = 1'b0;
        head    = '0;
        if (m_busy) begin
            avail = (fifo[m_grant].size() > 0);
            if (avail) head = fifo[m_grant][0];
            e_data  = {4'b0000, m_grant[2:0], head};
            e_valid = avail && !rst;
            hs      = e_valid && rdy;
            if (hs) e_read[m_grant] = 1'b1;
        end
        e_wc    = WC_EN ? m_words[31:0] : 32'd0;
        s_valid = OUT_VALID;
        s_busy  = BUSY;
        s_read  = RX_READ;
        s_data  = OUT_DATA;
        s_wc    = WORD_CNT;
        if (model_on) begin
            checkOutput("model_valid", 32'(s_valid), 32'(e_valid));
            checkOutput("model_busy", 32'(s_busy), 32'(m_busy));
            checkOutput("model_read", 32'(s_read), 32'(e_read));
            checkOutput("model_data", s_data, e_data);
            checkOutput("model_wordcnt", s_wc, e_wc);
        end
        @(posedge BUS_CLK);
        #1;
        for (int i = 0; i < NUM_RX; i++) begin
            if (s_read[i]) pop_log.push_back(i);
        end
        if (hs) void'(fifo[m_grant].pop_front());
        if (rst) begin
            m_busy   = 1'b0;
            m_grant  = 0;
            m_last   = NUM_RX - 1;
            m_taken  = 0;
            m_words  = 0;
            model_on = 1'b1;
        end else if (m_busy) begin
            if (hs) begin
                m_taken++;
                if (m_words < 64'hFFFF_FFFF) m_words++;
            end
            if ((hs && m_taken == MAX_BURST) || !avail || !en[m_grant]) begin
                m_busy = 1'b0;
                m_last = m_grant;
            end
        end else begin
            for (int k = 1; k <= NUM_RX; k++) begin
                c = (m_last + k) % NUM_RX;
                if (!m_busy && en[c] && fifo[c].size() > 0) begin
                    m_busy  = 1'b1;
                    m_grant = c;
                    m_taken = 0;
                end
            end
        end
    endtask

    task automatic resetDut();
        for (int i = 0; i < NUM_RX; i++) fifo[i].delete();
        applyStimulus(1'b1, 1'b0, '1);
        applyStimulus(1'b1, 1'b0, '1);
        pop_log.delete();
    endtask

    task automatic waitPops(input int c, input int n, input int bound);
        int k;
        k = 0;
        while (countPops(c) < n && k < bound) begin
            applyStimulus(1'b0, 1'b1, '1);
            k++;
        end
        checkOutput($sformatf("wait_pops_ch%0d", c), countPops(c), n);
    endtask

    initial begin
        RESET     = 1'b1;
        OUT_READY = 1'b0;
        EN_MASK   = '0;
        RX_EMPTY  = '1;
        RX_DATA   = '0;
        resetDut();

        // ch0 and ch3 loaded: ch0 first, then ch3 after its empty-exit and one IDLE cycle.
        tbl[0] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 32'h0000_0000};
        tbl[1] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 32'h0000_0000};
        tbl[2] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h01, 32'h00A5_A5A5};
        tbl[3] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 32'h0000_0000};
        tbl[4] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 32'h0000_0000};
        tbl[5] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h08, 32'h07C3_C3C3};
        tbl[6] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 32'h0600_0000};
        tbl[7] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 32'h0000_0000};
        fifo[0].push_back(25'h0A5_A5A5);
        fifo[3].push_back(25'h1C3_C3C3);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].rdy, tbl[i].en);
            checkOutput($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].exp_valid));
            checkOutput($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].exp_busy));
            checkOutput($sformatf("tbl%0d_read", i), 32'(s_read), 32'(tbl[i].exp_read));
            checkOutput($sformatf("tbl%0d_data", i), s_data, tbl[i].exp_data);
        end

        // Burst rotation: ch2 and ch5 with 10 words each, bursts of 4.
        resetDut();
        pushWords(2, 10);
        pushWords(5, 10);
        cyc = 0;
        while (pop_log.size() < 20 && cyc < 200) begin
            applyStimulus(1'b0, 1'b1, '1);
            cyc++;
        end
        checkOutput("burst_total", pop_log.size(), 20);
        seq_ch  = '{2, 5, 2, 5, 2, 5};
        seq_len = '{4, 4, 4, 4, 2, 2};
        ord.delete();
        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < seq_len[j]; k++) ord.push_back(seq_ch[j]);
        end
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("burst_order%0d", i), (i < pop_log.size()) ? pop_log[i] : -1, ord[i]);
        end

        // Backpressure: OUT_READY low for 20 cycles while granted.
        resetDut();
        pushWords(4, 3);
        cyc = 0;
        do begin
            applyStimulus(1'b0, 1'b0, '1);
            cyc++;
        end while (!s_valid && cyc < 10);
        checkOutput("hold_start", 32'(s_valid), 32'd1);
        hold_exp = {4'b0000, 3'd4, fifo[4][0]};
        repeat (20) begin
            applyStimulus(1'b0, 1'b0, '1);
            checkOutput("hold_valid", 32'(s_valid), 32'd1);
            checkOutput("hold_data", s_data, hold_exp);
            checkOutput("hold_read", 32'(s_read), 32'd0);
            checkOutput("hold_wordcnt", s_wc, 32'd0);
        end
        repeat (8) applyStimulus(1'b0, 1'b1, '1);
        checkOutput("hold_drain", pop_log.size(), 3);

        // Mask drop on ch1 mid-burst: the coincident handshake completes, then ch1 is never granted.
        resetDut();
        pushWords(1, 8);
        pushWords(6, 4);
        waitPops(1, 2, 20);
        applyStimulus(1'b0, 1'b1, 8'hFD);
        checkOutput("mask_drop_pop", 32'(s_read), 32'h02);
        repeat (20) begin
            applyStimulus(1'b0, 1'b1, 8'hFD);
            checkOutput("mask_no_grant", 32'(BUSY && OUT_DATA[27:25] == 3'd1), 32'd0);
        end
        checkOutput("mask_ch1_pops", countPops(1), 3);
        checkOutput("mask_ch6_pops", countPops(6), 4);

        // Reset during a ch3 burst after 3 accepted words.
        resetDut();
        pushWords(3, 8);
        waitPops(3, 3, 20);
        pushWords(0, 2);
        applyStimulus(1'b1, 1'b1, '1);
        checkOutput("rst_mid_valid", 32'(s_valid), 32'd0);
        checkOutput("rst_mid_read", 32'(s_read), 32'd0);
        applyStimulus(1'b0, 1'b1, '1);
        checkOutput("rst_after_valid", 32'(s_valid), 32'd0);
        checkOutput("rst_after_busy", 32'(s_busy), 32'd0);
        checkOutput("rst_after_wordcnt", s_wc, 32'd0);
        applyStimulus(1'b0, 1'b1, '1);
        checkOutput("rst_next_valid", 32'(s_valid), 32'd1);
        checkOutput("rst_next_grant", 32'(s_data[27:25]), 32'd0);
        checkOutput("rst_ch3_pops", countPops(3), 3);

        // 100 words transferred; WORD_CNT tracks accepted words only when the counter is built.
        resetDut();
        for (int i = 0; i < 100; i++) pushWords(i % NUM_RX, 1);
        cyc = 0;
        while (pop_log.size() < 100 && cyc < 1000) begin
            expw = WC_EN ? pop_log.size() : 0;
            applyStimulus(1'b0, 1'b1, '1);
            checkOutput("wc_100", s_wc, expw);
            cyc++;
        end
        checkOutput("wc_100_words", pop_log.size(), 100);

        // Randomized traffic, backpressure, masking and occasional reset against the model.
        resetDut();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                ch = $urandom_range(0, NUM_RX - 1);
                if (fifo[ch].size() < 12) pushWords(ch, $urandom_range(1, 3));
            end
            for (int i = 0; i < NUM_RX; i++) en_r[i] = ($urandom_range(0, 7) != 0);
            applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), en_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        tests_failed++;
        $display("[TB] FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rx_link_arbiter.md
RX_LINK_ARBITER -- requirements
Module: rx_link_arbiter

Interface
REQ-001 SHALL have parameter NUM_RX, default 8, number of receiver channels served (legal 1..8).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum words taken from one channel per grant (legal 1..256).
REQ-003 SHALL have parameter DATA_SIZE, default 25, per-channel FIFO word width (fixed 25).
REQ-004 SHALL have one clock and a synchronous, active-high reset: BUS_CLK input 1 (sole clock; all logic on posedge), RESET input 1 (synchronous, active-high).
REQ-005 SHALL have RX_EMPTY input NUM_RX, per-channel receiver FIFO empty flag.
REQ-006 SHALL have RX_DATA input NUM_RX*25, per-channel first-word-fall-through FIFO head word, channel i at bits [25*i+24:25*i].
REQ-007 SHALL have RX_READ output NUM_RX, per-channel one-cycle pop strobe.
REQ-008 SHALL have EN_MASK input NUM_RX, per-channel service enable.
REQ-009 SHALL have OUT_VALID output 1, output word valid.
REQ-010 SHALL have OUT_READY input 1, downstream accepts the word.
REQ-011 SHALL have OUT_DATA output 32, {4'b0000, channel[2:0], word[24:0]}.
REQ-012 SHALL have BUSY output 1, high while a channel is granted.
REQ-013 SHALL have WORD_CNT output 32, count of accepted words (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE and XFER.
REQ-015 In IDLE, SHALL search channels in rotating order last+1 ... last+NUM_RX (mod NUM_RX) for the first channel with EN_MASK=1 and RX_EMPTY=0.
REQ-016 On a search hit in IDLE, SHALL load grant with that channel, clear burst_cnt and enter XFER on the next edge; on a miss, SHALL stay in IDLE.
REQ-017 In XFER, SHALL drive OUT_VALID = !RX_EMPTY[grant] combinationally, and OUT_DATA from RX_DATA[grant] with channel id = grant.
REQ-018 In IDLE, SHALL hold OUT_VALID=0 and OUT_DATA=0.
REQ-019 SHALL drive RX_READ[grant] = OUT_VALID & OUT_READY; all other RX_READ bits SHALL be 0; at most one bit high per cycle.
REQ-020 SHALL increment burst_cnt on each handshake (OUT_VALID & OUT_READY).
REQ-021 SHALL leave XFER for IDLE and set last<=grant when any of the following holds: a handshake with burst_cnt==MAX_BURST-1; RX_EMPTY[grant]=1; EN_MASK[grant]=0.
REQ-022 Exit priority SHALL be: a handshake occurring in the same cycle as EN_MASK drop completes (the word is popped), then the FSM exits.
REQ-023 Latency SHALL be: non-empty seen in IDLE at cycle t gives OUT_VALID at t+1; re-arbitration after exit costs exactly one IDLE cycle.
REQ-024 OUT_DATA and OUT_VALID SHALL remain stable while OUT_VALID=1 and OUT_READY=0, provided the source FIFO is stable.
REQ-025 BUSY SHALL be 1 exactly when state==XFER.
REQ-026 If NUM_RX=1, SHALL always select channel 0 and still obey MAX_BURST exit.

Reset
REQ-027 On RESET=1 at a posedge, SHALL set state=IDLE, last=NUM_RX-1 (channel 0 first priority), grant=0, burst_cnt=0 and WORD_CNT=0.
REQ-028 Reset asserted mid-XFER SHALL drop OUT_VALID and RX_READ to 0 from the next cycle; no word SHALL be popped in the reset cycle.

Configuration
REQ-029 With macro RX_ARB_WORD_CNT_EN defined, WORD_CNT SHALL increment by 1 per handshake, saturate at 32'hFFFFFFFF, and clear on reset.
REQ-030 With RX_ARB_WORD_CNT_EN undefined, WORD_CNT SHALL be constant 0 and no counter logic SHALL be synthesized.

Structure
REQ-031 Package rx_arb_pkg SHALL hold the FSM state encoding, OUT_DATA field positions/widths (ID_LSB=25, ID_WIDTH=3, OUT_WIDTH=32) and DATA_SIZE=25.
REQ-032 Sub-module rx_rr_select (combinational rotating priority pick: inputs req, last; outputs hit, idx) SHALL implement REQ-015.

Verification
REQ-033 Bench SHALL cover: reset, ch0 and ch3 non-empty, OUT_READY=1 -> ch0 served first, OUT_DATA[27:25]=0, then ch3 after one IDLE cycle.
REQ-034 Bench SHALL cover: MAX_BURST=4, ch2 holding 10 words, ch5 holding 10 words, OUT_READY=1 -> order 4×ch2, 4×ch5, 4×ch2, 4×ch5, 2×ch2, 2×ch5.
REQ-035 Bench SHALL cover: OUT_READY=0 for 20 cycles during XFER -> OUT_VALID held at 1, OUT_DATA stable, RX_READ all 0, WORD_CNT unchanged.
REQ-036 Bench SHALL cover: EN_MASK[1] cleared mid-burst on ch1 -> at most the current handshake word popped, IDLE next, ch1 never granted while masked.
REQ-037 Bench SHALL cover: RESET asserted during XFER with 3 words accepted -> OUT_VALID=0 next cycle, WORD_CNT=0 (macro defined), next grant is ch0.
REQ-038 Bench SHALL cover: build without RX_ARB_WORD_CNT_EN, 100 words transferred -> WORD_CNT reads 0 throughout.
